// File: rtl/status_register_unit_if.sv
// Decode/execute/status-write bundle between the pipeline and the status register unit.
// The master side is the pipeline; the slave side is status_register_unit.
interface status_register_unit_if #(
    parameter int CNT_W = 2
);
    logic             freeze;
    logic             flush;
    logic             issue_valid;
    logic             issue_s;
    logic [3:0]       issue_cond;
    logic             wb_valid;
    logic             wb_s;
    logic [3:0]       wb_flags;
    logic             msr_valid;
    logic [3:0]       msr_flags;
    logic [3:0]       stat_reg;
    logic             flags_hazard;
    logic [CNT_W-1:0] pending_cnt;
    logic             pend_err;

    modport master (
        output freeze, flush,
        output issue_valid, issue_s, issue_cond,
        output wb_valid, wb_s, wb_flags,
        output msr_valid, msr_flags,
        input  stat_reg, flags_hazard, pending_cnt, pend_err
    );

    modport slave (
        input  freeze, flush,
        input  issue_valid, issue_s, issue_cond,
        input  wb_valid, wb_s, wb_flags,
        input  msr_valid, msr_flags,
        output stat_reg, flags_hazard, pending_cnt, pend_err
    );
endinterface

// File: rtl/status_register_unit.sv
// Architectural {z,c,n,v} status register with in-flight flag-setter tracking
// and a decode stall when a conditional instruction would read stale flags.
module status_register_unit #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    status_register_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [3:0]       COND_AL = 4'b1110;
    localparam logic [3:0]       COND_NV = 4'b1111;

    logic [3:0]       stat_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_p1;
    logic             err_nxt;
    logic             needs_flags;
    logic             hazard;
    logic             inc;
    logic             dec;

    assign needs_flags = (bus.issue_cond != COND_AL) && (bus.issue_cond != COND_NV);

    // No bypass of same-cycle wb_flags: a conditional waits for the count to drain.
    assign hazard = bus.issue_valid & ~bus.flush &
                    ((needs_flags & (cnt_p1 != '0)) |
                     (bus.issue_s & (cnt_p1 == CNT_MAX)));

    assign inc = bus.issue_valid & bus.issue_s & ~hazard & ~bus.freeze & ~bus.flush;
    assign dec = bus.wb_valid & bus.wb_s & ~bus.freeze;

    always_comb begin
        cnt_nxt = cnt_p1;
        err_nxt = err_p1;
        if (!bus.freeze) begin
            if (bus.flush) begin
                // A write-back landing with the flush is absorbed, never an underflow.
                cnt_nxt = '0;
            end else if (inc && !dec) begin
                cnt_nxt = cnt_p1 + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_p1 == '0) begin
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_p1 - CNT_W'(1);
                end
            end
        end
    end

    // Stage boundary: committed flags and pending-count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_p1 <= 4'b0000;
            cnt_p1  <= '0;
            err_p1  <= 1'b0;
        end else begin
            if (!bus.freeze) begin
                // Explicit status write wins over the ALU update; flush does not block either.
                if (bus.msr_valid) begin
                    stat_p1 <= bus.msr_flags;
                end else if (bus.wb_valid && bus.wb_s) begin
                    stat_p1 <= bus.wb_flags;
                end
            end
            cnt_p1 <= cnt_nxt;
            err_p1 <= err_nxt;
        end
    end

    assign bus.stat_reg     = stat_p1;
    assign bus.pending_cnt  = cnt_p1;
    assign bus.pend_err     = err_p1;
    assign bus.flags_hazard = hazard;
endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: directed scenarios followed by
// randomized traffic against a count-based reference model.
module tb_status_register_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    // Reference model state
    int   m_stat;
    int   m_pend;
    bit   m_err;

    status_register_unit_if #(.CNT_W(2)) bus ();

    status_register_unit #(
        .MAX_INFLIGHT(3),
        .CNT_W       (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hazard(input bit iv, input bit is, input logic [3:0] ic, input bit fl);
        bit needs;
        needs = (ic != 4'd14) && (ic != 4'd15);
        return iv && !fl && ((needs && m_pend != 0) || (is && m_pend == 3));
    endfunction

    task automatic drive(input bit fz, input bit fl, input bit iv, input bit is, input logic [3:0] ic,
                         input bit wv, input bit ws, input logic [3:0] wf,
                         input bit mv, input logic [3:0] mf);
        bus.freeze      = fz;
        bus.flush       = fl;
        bus.issue_valid = iv;
        bus.issue_s     = is;
        bus.issue_cond  = ic;
        bus.wb_valid    = wv;
        bus.wb_s        = ws;
        bus.wb_flags    = wf;
        bus.msr_valid   = mv;
        bus.msr_flags   = mf;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_stat"}, 32'(bus.stat_reg), 32'(m_stat));
        chk({tag, "_cnt"}, 32'(bus.pending_cnt), 32'(m_pend));
        chk({tag, "_err"}, 32'(bus.pend_err), 32'(m_err));
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input bit fz, input bit fl, input bit iv, input bit is, input logic [3:0] ic,
                       input bit wv, input bit ws, input logic [3:0] wf,
                       input bit mv, input logic [3:0] mf);
        bit haz;
        int inc;
        int dec;
        drive(fz, fl, iv, is, ic, wv, ws, wf, mv, mf);
        #4;
        haz = m_hazard(iv, is, ic, fl);
        chk("hazard", 32'(bus.flags_hazard), 32'(haz));
        check_state("pre");
        @(posedge clk);
        if (!fz) begin
            if (mv) m_stat = int'(mf);
            else if (wv && ws) m_stat = int'(wf);
            inc = (iv && is && !haz && !fl) ? 1 : 0;
            dec = (wv && ws) ? 1 : 0;
            if (fl) begin
                m_pend = 0;
            end else begin
                m_pend = m_pend + inc - dec;
                if (m_pend < 0) begin
                    m_pend = 0;
                    m_err  = 1'b1;
                end
            end
        end
        #1;
        check_state("post");
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 4'd14, 0, 0, 4'd0, 0, 4'd0);
    endtask

    // Asserts reset in the middle of a cycle with a BEQ presented, checks the
    // immediate effect, and releases it well away from the clock edge.
    task automatic mid_reset(input string tag);
        drive(0, 0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        m_stat = 0;
        m_pend = 0;
        m_err  = 1'b0;
        chk({tag, "_stat"}, 32'(bus.stat_reg), 32'd0);
        chk({tag, "_cnt"}, 32'(bus.pending_cnt), 32'd0);
        chk({tag, "_err"}, 32'(bus.pend_err), 32'd0);
        chk({tag, "_haz"}, 32'(bus.flags_hazard), 32'd0);
        drive(0, 0, 0, 0, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_stat = 0;
        m_pend = 0;
        m_err  = 1'b0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        #3;
        chk("rst_stat", 32'(bus.stat_reg), 32'd0);
        chk("rst_cnt", 32'(bus.pending_cnt), 32'd0);
        chk("rst_err", 32'(bus.pend_err), 32'd0);
        chk("rst_haz", 32'(bus.flags_hazard), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // S instruction, then BEQ stalls until its write-back commits
        cyc(0, 0, 1, 1, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        drive(0, 0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        #1;
        chk("beq_haz", 32'(bus.flags_hazard), 32'd1);
        cyc(0, 0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        cyc(0, 0, 1, 0, 4'd0, 1, 1, 4'b1000, 0, 4'd0);
        chk("beq_stat", 32'(bus.stat_reg), 32'b1000);
        chk("beq_cnt", 32'(bus.pending_cnt), 32'd0);
        drive(0, 0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
        #1;
        chk("beq_haz_drop", 32'(bus.flags_hazard), 32'd0);
        cyc(0, 0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);

        // Fill to MAX_INFLIGHT, then a 4th setter stalls until a write-back frees a slot
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        chk("full_cnt", 32'(bus.pending_cnt), 32'd3);
        drive(0, 0, 1, 1, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        #1;
        chk("full_haz", 32'(bus.flags_hazard), 32'd1);
        cyc(0, 0, 1, 1, 4'd14, 1, 1, 4'b0001, 0, 4'd0);
        chk("full_dec_cnt", 32'(bus.pending_cnt), 32'd2);
        cyc(0, 0, 1, 1, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        chk("full_reissue_cnt", 32'(bus.pending_cnt), 32'd3);

        // Explicit write beats same-cycle ALU update; counter still decrements
        cyc(0, 0, 0, 0, 4'd14, 1, 1, 4'b1010, 1, 4'b0101);
        chk("msr_stat", 32'(bus.stat_reg), 32'b0101);
        chk("msr_cnt", 32'(bus.pending_cnt), 32'd2);

        // Flush with a write-back: flags commit, count clears, no error
        cyc(0, 1, 0, 0, 4'd14, 1, 1, 4'b0010, 0, 4'd0);
        chk("flush_stat", 32'(bus.stat_reg), 32'b0010);
        chk("flush_cnt", 32'(bus.pending_cnt), 32'd0);
        chk("flush_err", 32'(bus.pend_err), 32'd0);
        cyc(0, 0, 0, 0, 4'd14, 1, 1, 4'b0100, 0, 4'd0);
        chk("uflow_err", 32'(bus.pend_err), 32'd1);
        idle_cyc();
        chk("uflow_sticky", 32'(bus.pend_err), 32'd1);

        // Freeze blocks every state change
        cyc(0, 0, 1, 1, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 1, 4'd14, 1, 1, 4'b1111, 1, 4'b1001);
            chk("frz_stat", 32'(bus.stat_reg), 32'b0100);
            chk("frz_cnt", 32'(bus.pending_cnt), 32'd1);
            chk("frz_err", 32'(bus.pend_err), 32'd1);
        end

        // Mid-cycle reset with two setters in flight
        cyc(0, 0, 1, 1, 4'd14, 0, 0, 4'd0, 0, 4'd0);
        chk("pre_rst_cnt", 32'(bus.pending_cnt), 32'd2);
        mid_reset("mrst");

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            bit fz, fl, iv, is, wv, ws, mv;
            logic [3:0] ic, wf, mf;
            fz = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 11) == 0);
            iv = ($urandom_range(0, 9) < 7);
            is = $urandom_range(0, 1) == 1;
            ic = ($urandom_range(0, 1) == 1) ? 4'd14 : 4'($urandom_range(0, 15));
            wv = $urandom_range(0, 1) == 1;
            ws = ($urandom_range(0, 9) < 6);
            wf = 4'($urandom_range(0, 15));
            mv = ($urandom_range(0, 7) == 0);
            mf = 4'($urandom_range(0, 15));
            cyc(fz, fl, iv, is, ic, wv, ws, wf, mv, mf);
            if (n % 150 == 149) mid_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
